// File: rtl/demux_1_4_behavioral_pkg.sv
// Shared select encoding for the registered 1-to-4 demultiplexer.
package demux_1_4_behavioral_pkg;

    localparam logic [1:0] SEL_Y1 = 2'b00;
    localparam logic [1:0] SEL_Y2 = 2'b01;
    localparam logic [1:0] SEL_Y3 = 2'b10;
    localparam logic [1:0] SEL_Y4 = 2'b11;

    function automatic logic [1:0] sel_of(input logic s2, input logic s1);
        return {s2, s1};
    endfunction

endpackage

// File: rtl/demux_1_4_decode.sv
// Combinational next-value decode: routes A to the selected output, zeros elsewhere.
module demux_1_4_decode
    import demux_1_4_behavioral_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y1_d,
    output logic [WIDTH-1:0] y2_d,
    output logic [WIDTH-1:0] y3_d,
    output logic [WIDTH-1:0] y4_d
);

    always_comb begin
        y1_d = '0;
        y2_d = '0;
        y3_d = '0;
        y4_d = '0;
        // An unknown select falls through to the default, keeping all outputs at 0.
        case (sel)
            SEL_Y1:  y1_d = a;
            SEL_Y2:  y2_d = a;
            SEL_Y3:  y3_d = a;
            SEL_Y4:  y4_d = a;
            default: ;
        endcase
    end

endmodule

// File: rtl/demux_1_4_behavioral.sv
// 1-to-4 demultiplexer with asynchronously reset, registered outputs.
module demux_1_4_behavioral
    import demux_1_4_behavioral_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             S2,
    input  logic             S1,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [WIDTH-1:0] Y4
);

    logic [WIDTH-1:0] y1_d, y2_d, y3_d, y4_d;
    logic [WIDTH-1:0] y1_q, y2_q, y3_q, y4_q;

    demux_1_4_decode #(
        .WIDTH(WIDTH)
    ) u_decode (
        .sel  (sel_of(S2, S1)),
        .a    (A),
        .y1_d (y1_d),
        .y2_d (y2_d),
        .y3_d (y3_d),
        .y4_d (y4_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y1_q <= '0;
            y2_q <= '0;
            y3_q <= '0;
            y4_q <= '0;
        end else begin
            y1_q <= y1_d;
            y2_q <= y2_d;
            y3_q <= y3_d;
            y4_q <= y4_d;
        end
    end

    assign Y1 = y1_q;
    assign Y2 = y2_q;
    assign Y3 = y3_q;
    assign Y4 = y4_q;

endmodule

// File: tb/tb_demux_1_4_behavioral.sv
// Self-checking bench: directed scenarios plus randomized traffic against an array model.
module tb_demux_1_4_behavioral;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         S2, S1;
    logic [W-1:0] A;
    logic [W-1:0] Y1, Y2, Y3, Y4;

    int passed = 0;
    int total  = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] exp_y [4];

    demux_1_4_behavioral #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .S2  (S2),
        .S1  (S1),
        .A   (A),
        .Y1  (Y1),
        .Y2  (Y2),
        .Y3  (Y3),
        .Y4  (Y4)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    task automatic check4(input string name, input logic [W-1:0] e1, input logic [W-1:0] e2,
                          input logic [W-1:0] e3, input logic [W-1:0] e4);
        check({name, ".Y1"}, Y1, e1);
        check({name, ".Y2"}, Y2, e2);
        check({name, ".Y3"}, Y3, e3);
        check({name, ".Y4"}, Y4, e4);
    endtask

    // Reference: output index = select value; that one takes A, the rest are zero.
    always @(posedge clk or posedge rst) begin
        int idx;
        if (rst || $isunknown({S2, S1})) begin
            for (int i = 0; i < 4; i++) exp_y[i] = '0;
        end else begin
            idx = 2 * int'(S2) + int'(S1);
            for (int i = 0; i < 4; i++) exp_y[i] = (i == idx) ? A : '0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) check4("model", exp_y[0], exp_y[1], exp_y[2], exp_y[3]);
    end

    task automatic drive(input logic s2, input logic s1, input logic [W-1:0] a);
        @(posedge clk);
        #1;
        S2 = s2;
        S1 = s1;
        A  = a;
    endtask

    initial begin
        logic [1:0] sw;

        // Inputs untouched before the first edge: outputs must come out 0, not X.
        @(posedge clk);
        #1;
        check4("x_sel", '0, '0, '0, '0);
        chk_en = 1'b1;

        // Reset, then release with sel=00, A=1.
        rst = 1'b1;
        #2;
        check4("reset", '0, '0, '0, '0);
        S2 = 1'b0; S1 = 1'b0; A = 4'h1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check4("sel00", 4'h1, '0, '0, '0);

        drive(1'b0, 1'b1, 4'h1);
        @(posedge clk); #1;
        check4("sel01", '0, 4'h1, '0, '0);
        S2 = 1'b1; S1 = 1'b0;
        @(posedge clk); #1;
        check4("sel10", '0, '0, 4'h1, '0);
        S2 = 1'b1; S1 = 1'b1;
        @(posedge clk); #1;
        check4("sel11", '0, '0, '0, 4'h1);
        A = 4'h0;
        @(posedge clk); #1;
        check4("a_zero", '0, '0, '0, '0);

        // Async reset while Y4 is high must clear before the next edge.
        A = 4'h1;
        @(posedge clk); #1;
        check4("y4_hold", '0, '0, '0, 4'h1);
        #1 rst = 1'b1;
        #1;
        check4("async_rst", '0, '0, '0, '0);
        @(negedge clk);
        rst = 1'b0;

        // Sweep 00..11 gives one-hot in order.
        for (int s = 0; s < 4; s++) begin
            sw = s[1:0];
            S2 = sw[1]; S1 = sw[0]; A = 4'h1;
            @(posedge clk); #1;
            check("sweep.Y1", Y1, (s == 0) ? 4'h1 : 4'h0);
            check("sweep.Y2", Y2, (s == 1) ? 4'h1 : 4'h0);
            check("sweep.Y3", Y3, (s == 2) ? 4'h1 : 4'h0);
            check("sweep.Y4", Y4, (s == 3) ? 4'h1 : 4'h0);
        end

        // Mid-cycle select change must not show until the next rising edge.
        S2 = 1'b0; S1 = 1'b0; A = 4'hA;
        @(posedge clk); #1;
        check4("lat_pre", 4'hA, '0, '0, '0);
        S1 = 1'b1; A = 4'h5;
        #3;
        check4("lat_mid", 4'hA, '0, '0, '0);
        @(posedge clk); #1;
        check4("lat_post", '0, 4'h5, '0, '0);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
            S2 = 1'($urandom);
            S1 = 1'($urandom);
            A  = W'($urandom);
            if ($urandom_range(0, 31) == 0) begin
                rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
